kernel3_gmem_b_m_axi_burst_split: RTL
=====================================

Name: kernel3_gmem_B_m_axi_burst_split

Overview:
Read-address burst splitter placed directly upstream of the gmem_B m_axi register slice on the AR path. It accepts one linear read request (byte address plus total beat count) from the kernel-side request queue. It emits a sequence of AXI-legal bursts that never exceed MAX_BURST beats and never cross a 4 KB boundary. Its output port pairs one-to-one with the register slice's s_data/s_valid/s_ready interface.

Parameters:
ADDR_WIDTH, 64, byte-address width.
LEN_WIDTH, 32, width of request beat count.
DATA_BYTES, 64, bus width in bytes; power of two, 1..4096.
MAX_BURST, 16, max beats per output burst; power of two, 1..256.

Ports:
clk  in  1  clock.
reset_n  in  1  asynchronous active-low reset.
req_addr  in  ADDR_WIDTH  start byte address; low log2(DATA_BYTES) bits ignored (treated as 0).
req_len  in  LEN_WIDTH  total beats requested; 0 = empty request.
req_valid  in  1  request valid.
req_ready  out  1  request accepted when req_valid & req_ready.
out_addr  out  ADDR_WIDTH  burst start address (beat-aligned).
out_len  out  8  AXI ARLEN (beats-1).
out_last  out  1  final burst of the current request.
out_valid  out  1  burst valid.
out_ready  in  1  downstream ready (register slice s_ready).

Behaviour:
- Reset (async assert, sync release): state=IDLE; req_ready=0 during reset, 1 in first cycle after release; out_valid=0, out_len=0, out_addr=0, out_last=0.
- States: IDLE, SPLIT.
- IDLE: req_ready=1. On req_valid with req_len!=0: latch aligned addr into cur_addr and req_len into remaining; go to SPLIT. On req_valid with req_len==0: request consumed; no output; stay IDLE.
- Burst calc (combinational on cur_addr/remaining): to_4k = (4096 - cur_addr[11:0]) / DATA_BYTES; beats = min(remaining, MAX_BURST, to_4k), always ≥1.
- SPLIT: output registered. out_valid asserts the cycle after acceptance, so latency is 1 cycle from request handshake to first burst valid.
  - out_addr = cur_addr; out_len = beats-1; out_last = (beats==remaining).
  - out_* are held stable while out_valid & ~out_ready.
  - On handshake: cur_addr += beats*DATA_BYTES; remaining -= beats.
  - If out_last: next cycle out_valid=0 and go to IDLE, so req_ready=1 that cycle. Otherwise the next burst is valid in the very next cycle (one burst per cycle at full throughput).
- req_ready=0 throughout SPLIT; no request overlap.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; no error flag.
- Reset mid-SPLIT: all pending bursts are discarded; no partial output after release.

Optional Feature:
KERNEL3_BURST_SPLIT_STAT_EN
- Defined: adds output burst_count (32 bits). It increments on each out handshake, saturates at 0xFFFFFFFF, and is cleared by reset.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package kernel3_gmem_B_m_axi_pkg: BOUNDARY_BYTES=4096 localparam, state enum (IDLE, SPLIT), ARLEN width constant (8).
- Sub-module kernel3_gmem_B_m_axi_burst_len_calc: purely combinational (cur_addr, remaining) -> (beats, is_last). Instantiated once.

Test Plan:
- Basic split: addr=0x0, len=40, out_ready=1 -> bursts (0x000,15,last=0), (0x400,15,0), (0x800,7,1) on consecutive cycles; req_ready=1 the cycle after the last handshake.
- 4K crossing: addr=0xF80, len=4 -> (0xF80,len=1,0), (0x1000,len=1,1).
- Backpressure: addr=0x0, len=20, out_ready=0 for 5 cycles after first valid -> out_addr=0x0/out_len=15 held stable all 5 cycles; then (0x400,3,last=1).
- Zero length: req_len=0, req_valid=1 for one cycle -> out_valid never asserts; req_ready stays 1; next request len=1 at addr=0x40 -> (0x40,0,1).
- Unaligned address: addr=0x47, len=1 -> out_addr=0x40.
- Reset mid-op: addr=0x0, len=64, assert reset_n=0 after 2nd handshake -> out_valid=0 immediately (async); after release no further bursts; state IDLE. With KERNEL3_BURST_SPLIT_STAT_EN defined, burst_count=0 after reset and 4 after a clean len=64 request.

Source files
------------

// File: rtl/kernel3_gmem_b_m_axi_pkg.sv
// Shared constants and state encoding for the gmem_B read-address burst splitter.
package kernel3_gmem_b_m_axi_pkg;

    localparam int BOUNDARY_BYTES = 4096;
    localparam int BOUNDARY_BITS  = $clog2(BOUNDARY_BYTES);
    localparam int ARLEN_WIDTH    = 8;
    localparam int BEATS_WIDTH    = ARLEN_WIDTH + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_e;

endpackage

// File: rtl/kernel3_gmem_b_m_axi_burst_len_calc.sv
// Combinational burst sizing: beats = min(remaining, MAX_BURST, beats left before the 4 KB line).
module kernel3_gmem_b_m_axi_burst_len_calc
    import kernel3_gmem_b_m_axi_pkg::*;
#(
    parameter int LEN_WIDTH  = 32,
    parameter int DATA_BYTES = 64,
    parameter int MAX_BURST  = 16
) (
    input  logic [BOUNDARY_BITS-1:0] addr_off,
    input  logic [LEN_WIDTH-1:0]     remaining,
    output logic [BEATS_WIDTH-1:0]   beats,
    output logic                     is_last
);

    localparam int BEAT_SHIFT = $clog2(DATA_BYTES);
    localparam int SPAN_W     = BOUNDARY_BITS + 1;

    logic [SPAN_W-1:0] span;
    logic [SPAN_W-1:0] to_4k;
    logic [SPAN_W-1:0] cap;

    // NOTE: every output gets a value on every path so no latch is inferred.
    always_comb begin
        span    = SPAN_W'(BOUNDARY_BYTES) - {1'b0, addr_off};
        to_4k   = span >> BEAT_SHIFT;
        cap     = (to_4k < SPAN_W'(MAX_BURST)) ? to_4k : SPAN_W'(MAX_BURST);
        is_last = (remaining <= LEN_WIDTH'(cap));
        beats   = is_last ? BEATS_WIDTH'(remaining) : BEATS_WIDTH'(cap);
    end

endmodule

// File: rtl/kernel3_gmem_b_m_axi_burst_split.sv
// Splits one linear read request into AXI bursts (<= MAX_BURST beats, no 4 KB crossing).
// Optional KERNEL3_BURST_SPLIT_STAT_EN adds a saturating burst_count output.
module kernel3_gmem_b_m_axi_burst_split
    import kernel3_gmem_b_m_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int LEN_WIDTH  = 32,
    parameter int DATA_BYTES = 64,
    parameter int MAX_BURST  = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [LEN_WIDTH-1:0]   req_len,
    input  logic                   req_valid,
    output logic                   req_ready,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic [ARLEN_WIDTH-1:0] out_len,
    output logic                   out_last,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef KERNEL3_BURST_SPLIT_STAT_EN
    ,
    output logic [31:0]            burst_count
`endif
);

    localparam int BEAT_SHIFT = $clog2(DATA_BYTES);
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ADDR_WIDTH'(DATA_BYTES - 1);

    state_e                  state;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [LEN_WIDTH-1:0]    remaining;

    logic [ADDR_WIDTH-1:0]   calc_addr;
    logic [LEN_WIDTH-1:0]    calc_rem;
    logic [BEATS_WIDTH-1:0]  beats;
    logic [BEATS_WIDTH-1:0]  beats_m1;
    logic                    is_last;
    logic                    out_fire;
    logic                    accept;
    logic                    load;

    // cur_addr/remaining describe the burst after the one on the output, so the
    // sizing logic always looks at the burst that is about to be registered.
    always_comb begin
        calc_addr = (state == IDLE) ? (req_addr & ~BEAT_MASK) : cur_addr;
        calc_rem  = (state == IDLE) ? req_len : remaining;
        beats_m1  = beats - BEATS_WIDTH'(1);
        out_fire  = out_valid & out_ready;
        accept    = (state == IDLE) & req_valid & (req_len != '0);
        load      = accept | ((state == SPLIT) & out_fire & ~out_last);
    end

    assign req_ready = reset_n & (state == IDLE);

    kernel3_gmem_b_m_axi_burst_len_calc #(
        .LEN_WIDTH  (LEN_WIDTH),
        .DATA_BYTES (DATA_BYTES),
        .MAX_BURST  (MAX_BURST)
    ) u_len_calc (
        .addr_off  (calc_addr[BOUNDARY_BITS-1:0]),
        .remaining (calc_rem),
        .beats     (beats),
        .is_last   (is_last)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            out_addr  <= '0;
            out_len   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (accept) state <= SPLIT;
                SPLIT:   if (out_fire && out_last) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (load) begin
                out_addr  <= calc_addr;
                out_len   <= beats_m1[ARLEN_WIDTH-1:0];
                out_last  <= is_last;
                out_valid <= 1'b1;
                cur_addr  <= calc_addr + (ADDR_WIDTH'(beats) << BEAT_SHIFT);
                remaining <= calc_rem - LEN_WIDTH'(beats);
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef KERNEL3_BURST_SPLIT_STAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burst_count <= '0;
        end else if (out_fire && (burst_count != '1)) begin
            burst_count <= burst_count + 32'd1;
        end
    end
`endif

endmodule
